riscv_test_monitor: RTL and testbench
=====================================

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, writeback data width
- ADDR_W, 32, PC width
- CNT_W, 32, cycle/retire counter width
- TIMEOUT_CYCLES, 750, RUN cycles before timeout (replaces fixed-delay stop)
- STALL_LIMIT, 16, consecutive cycles of unchanged PC declared a hang
- PASS_SIG, 32'h0000_600D, writeback value signalling pass
- FAIL_SIG, 32'h0000_0BAD, writeback value signalling fail
- TRACE_DEPTH, 8, PC trace entries (power of 2)
REQ-002 Ports (name direction width meaning), one per line:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; starts monitoring from IDLE
- clear  in  1  synchronous return to IDLE, counters zeroed
- wb_valid  in  1  writeback stage retiring an instruction this cycle
- WB_Data  in  DATA_W  writeback data
- Address  in  ADDR_W  current fetch PC
- trace_idx  in  $clog2(TRACE_DEPTH)  trace read index, 0 = most recent
- done  out  1  in a terminal state
- pass, fail, timeout, hang  out  1 each  terminal cause, one-hot when done
- cycle_count  out  CNT_W  cycles spent in RUN
- retire_count  out  CNT_W  wb_valid cycles seen in RUN
- trace_pc  out  ADDR_W  trace entry selected by trace_idx

Function
REQ-003 FSM states IDLE, RUN, PASS, FAIL, HANG, TIMEOUT; all outputs registered except trace_pc.
REQ-004 IDLE -> RUN on the first edge with enable=1; counters stay 0 in IDLE.
REQ-005 RUN: cycle_count +1 per cycle; retire_count +1 per wb_valid cycle; both saturate at all-ones.
REQ-006 RUN exit priority per cycle: wb_valid & WB_Data==PASS_SIG -> PASS; else wb_valid & WB_Data==FAIL_SIG -> FAIL; else stall counter == STALL_LIMIT-1 with Address unchanged -> HANG; else cycle_count == TIMEOUT_CYCLES-1 -> TIMEOUT.
REQ-007 Stall counter: +1 when Address equals last-cycle Address, zeroed on change; cleared entering RUN; first RUN cycle compares against a captured reference, never reset-value PC.
REQ-008 The exit cycle is counted: cycle_count and retire_count include it; counters freeze in terminal states.
REQ-009 Terminal states hold until clear or reset; enable ignored outside IDLE; deasserting enable in RUN has no effect.
REQ-010 done and the matching cause flag assert the cycle after the exit condition (one-cycle latency).
REQ-011 clear wins over every FSM transition and counter update in the same cycle; enable=1 with clear=1 stays IDLE.
REQ-012 Signature compare uses the full DATA_W bits; WB_Data is ignored when wb_valid=0.

Reset
REQ-013 reset asserted: state=IDLE, done/pass/fail/timeout/hang=0, counters=0, stall counter=0, trace entries=0, trace pointer=0, immediately and independent of clk.
REQ-014 reset mid-RUN aborts the test; monitor restarts only on enable after deassertion.

Configuration
REQ-015 Macro RISCV_TEST_MONITOR_TRACE_EN defined: circular buffer of TRACE_DEPTH PCs, written with Address on every wb_valid cycle in RUN, pointer wraps modulo TRACE_DEPTH; trace_pc = entry written trace_idx writes ago, combinational.
REQ-016 Macro undefined: no trace storage; trace_pc tied to 0; all other behaviour identical.

Verification (TIMEOUT_CYCLES=100, STALL_LIMIT=8)
REQ-017 enable at cycle 0, wb_valid each cycle with incrementing PC, WB_Data=32'h600D on the 5th retire -> pass=1, done=1 next cycle, retire_count=5, cycle_count=5.
REQ-018 Same stream, WB_Data=32'h0BAD and 32'h600D both never matched until FAIL_SIG at retire 3 -> fail=1, pass=0; values held 20 further cycles.
REQ-019 Address frozen at 32'h40 from RUN cycle 10 -> hang=1 after exactly 8 equal-PC cycles; cycle_count=18.
REQ-020 PC always changing, no signature -> timeout=1 with cycle_count=100; then clear -> IDLE, all outputs 0.
REQ-021 reset pulsed at RUN cycle 30, enable reasserted -> counters restart from 0; reset with enable held high -> RUN entered on first edge after deassertion.
REQ-022 With TRACE_EN, 11 retires with PCs 0x0,0x4..0x28 -> trace_idx=0 gives 0x28, trace_idx=7 gives 0xC (wrap verified); without macro trace_pc=0.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Pass/fail/hang/timeout monitor for a RISC-V core under test, with cycle and retire counters.
// Optional PC trace buffer enabled by defining RISCV_TEST_MONITOR_TRACE_EN.
module riscv_test_monitor #(
  parameter int                 DATA_W         = 32,
  parameter int                 ADDR_W         = 32,
  parameter int                 CNT_W          = 32,
  parameter int                 TIMEOUT_CYCLES = 750,
  parameter int                 STALL_LIMIT    = 16,
  parameter logic [DATA_W-1:0]  PASS_SIG       = DATA_W'(32'h0000_600D),
  parameter logic [DATA_W-1:0]  FAIL_SIG       = DATA_W'(32'h0000_0BAD),
  parameter int                 TRACE_DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           wb_valid,
  input  logic [DATA_W-1:0]              WB_Data,
  input  logic [ADDR_W-1:0]              Address,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic                           hang,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               retire_count,
  output logic [ADDR_W-1:0]              trace_pc
);

  localparam int IDX_W   = $clog2(TRACE_DEPTH);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL, S_HANG, S_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   retire_count_q, retire_count_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [ADDR_W-1:0]  prev_addr_q, prev_addr_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic               hang_q, hang_d;
  logic               addr_same;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign addr_same = (Address == prev_addr_q);

  always_comb begin
    state_d        = state_q;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    stall_d        = stall_q;
    prev_addr_d    = prev_addr_q;
    done_d         = done_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    timeout_d      = timeout_q;
    hang_d         = hang_q;
    if (clear) begin
      state_d        = S_IDLE;
      cycle_count_d  = '0;
      retire_count_d = '0;
      stall_d        = '0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
      fail_d         = 1'b0;
      timeout_d      = 1'b0;
      hang_d         = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The reference PC is captured here so the first RUN cycle never sees the reset value.
          if (enable) begin
            state_d     = S_RUN;
            stall_d     = '0;
            prev_addr_d = Address;
          end
        end
        S_RUN: begin
          cycle_count_d = sat_inc(cycle_count_q);
          if (wb_valid) retire_count_d = sat_inc(retire_count_q);
          stall_d     = addr_same ? stall_q + STALL_W'(1) : '0;
          prev_addr_d = Address;
          if (wb_valid && (WB_Data == PASS_SIG)) begin
            state_d = S_PASS;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (wb_valid && (WB_Data == FAIL_SIG)) begin
            state_d = S_FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else if (addr_same && (stall_q == STALL_W'(STALL_LIMIT - 1))) begin
            state_d = S_HANG;
            done_d  = 1'b1;
            hang_d  = 1'b1;
          end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      stall_q        <= '0;
      prev_addr_q    <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      hang_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      stall_q        <= stall_d;
      prev_addr_q    <= prev_addr_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      hang_q         <= hang_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign hang         = hang_q;
  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;

`ifdef RISCV_TEST_MONITOR_TRACE_EN
  logic [ADDR_W-1:0] trace_q [TRACE_DEPTH];
  logic [ADDR_W-1:0] trace_d [TRACE_DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  rd_ptr;

  always_comb begin
    trace_d  = trace_q;
    wr_ptr_d = wr_ptr_q;
    if (!clear && (state_q == S_RUN) && wb_valid) begin
      trace_d[wr_ptr_q] = Address;
      wr_ptr_d          = wr_ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      trace_q  <= trace_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Index wraps modulo TRACE_DEPTH because the pointer width is exactly log2 of the depth.
  assign rd_ptr   = wr_ptr_q - IDX_W'(1) - trace_idx;
  assign trace_pc = trace_q[rd_ptr];
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomized and directed bench for riscv_test_monitor against a cycle-level outcome model.
// Define RISCV_TEST_MONITOR_TRACE_EN for both bench and RTL to exercise the trace buffer.
module tb_riscv_test_monitor;
  localparam int          TO     = 100;
  localparam int          SL     = 8;
  localparam int          TD     = 8;
  localparam logic [31:0] PASS_V = 32'h0000_600D;
  localparam logic [31:0] FAIL_V = 32'h0000_0BAD;
  localparam longint      CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, enable, clear, wb_valid;
  logic [31:0] WB_Data, Address;
  logic [2:0]  trace_idx;
  logic        done, pass, fail, timeout, hang;
  logic [31:0] cycle_count, retire_count, trace_pc;

  riscv_test_monitor #(
    .DATA_W(32), .ADDR_W(32), .CNT_W(32), .TIMEOUT_CYCLES(TO), .STALL_LIMIT(SL),
    .PASS_SIG(PASS_V), .FAIL_SIG(FAIL_V), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .wb_valid(wb_valid),
    .WB_Data(WB_Data), .Address(Address), .trace_idx(trace_idx),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .hang(hang),
    .cycle_count(cycle_count), .retire_count(retire_count), .trace_pc(trace_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outcome model: 0 idle, 1 run, 2 pass, 3 fail, 4 hang, 5 timeout
  int          m_phase;
  longint      m_cycles, m_retires;
  int          m_streak;
  logic [31:0] m_last;
  logic [31:0] hist[$];

  task automatic model_reset();
    m_phase = 0; m_cycles = 0; m_retires = 0; m_streak = 0; m_last = '0;
    hist.delete();
  endtask

  task automatic model_step(input logic en, clr, wbv, input logic [31:0] data, addr);
    if (clr) begin
      m_phase = 0; m_cycles = 0; m_retires = 0; m_streak = 0;
    end else if (m_phase == 0) begin
      if (en) begin m_phase = 1; m_last = addr; m_streak = 0; end
    end else if (m_phase == 1) begin
      if (m_cycles < CNT_MAX) m_cycles++;
      if (wbv) begin
        if (m_retires < CNT_MAX) m_retires++;
        hist.push_back(addr);
        if (hist.size() > TD) void'(hist.pop_front());
      end
      m_streak = (addr == m_last) ? m_streak + 1 : 0;
      m_last   = addr;
      if (wbv && data == PASS_V)      m_phase = 2;
      else if (wbv && data == FAIL_V) m_phase = 3;
      else if (m_streak == SL)        m_phase = 4;
      else if (m_cycles == TO)        m_phase = 5;
    end
  endtask

  function automatic logic [31:0] exp_trace(input logic [2:0] idx);
`ifdef RISCV_TEST_MONITOR_TRACE_EN
    if (int'(idx) < hist.size()) return hist[hist.size() - 1 - int'(idx)];
    return 32'h0;
`else
    return 32'h0 + 32'(idx & 3'b000);
`endif
  endfunction

  task automatic compare_all();
    check_val("done",    done,    m_phase >= 2);
    check_val("pass",    pass,    m_phase == 2);
    check_val("fail",    fail,    m_phase == 3);
    check_val("hang",    hang,    m_phase == 4);
    check_val("timeout", timeout, m_phase == 5);
    check_val("cycle_count",  cycle_count,  m_cycles);
    check_val("retire_count", retire_count, m_retires);
    check_val("trace_pc", trace_pc, exp_trace(trace_idx));
  endtask

  // Inputs change just after the falling edge; outputs are compared at the next falling edge.
  task automatic drive(input logic en, clr, wbv, input logic [31:0] data, addr, input logic [2:0] idx);
    enable = en; clear = clr; wb_valid = wbv; WB_Data = data; Address = addr; trace_idx = idx;
    @(posedge clk);
    if (!reset) model_step(en, clr, wbv, data, addr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset(input logic en_hold);
    enable = en_hold;
    reset  = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    #2 reset = 1'b0;
  endtask

  function automatic logic [31:0] nosig();
    logic [31:0] v;
    v = $urandom;
    if (v == PASS_V || v == FAIL_V) v = v ^ 32'h1;
    return v;
  endfunction

  function automatic logic [2:0] ridx();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [31:0] pc;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; wb_valid = 1'b0;
    WB_Data = '0; Address = '0; trace_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_val("rst_done", done, 0);
    check_val("rst_cycles", cycle_count, 0);
    reset = 1'b0;
    drive(0, 0, 0, PASS_V, 32'h10, 0);

    // Pass on the fifth retire
    pc = 32'h1000;
    drive(1, 0, 0, 0, pc, 0);
    for (int r = 1; r <= 5; r++) begin
      pc += 4;
      drive(1'($urandom_range(0, 1)), 0, 1, (r == 5) ? PASS_V : nosig(), pc, ridx());
    end
    check_val("a_pass", pass, 1);
    check_val("a_done", done, 1);
    check_val("a_retire", retire_count, 5);
    check_val("a_cycles", cycle_count, 5);
    repeat (3) drive(1'($urandom_range(0, 1)), 0, 1, FAIL_V, pc, ridx());
    drive(1, 1, 0, 0, pc, 0);
    check_val("a_clear_done", done, 0);

    // Fail at retire 3, near-miss signatures ignored, result held
    drive(1, 0, 0, 0, 32'h3000, 0);
    drive(0, 0, 0, PASS_V, 32'h3004, 0);
    drive(0, 0, 1, nosig(), 32'h3008, 0);
    drive(0, 0, 1, PASS_V ^ 32'h0001_0000, 32'h300C, 0);
    drive(0, 0, 1, FAIL_V, 32'h3010, 0);
    check_val("b_fail", fail, 1);
    check_val("b_pass", pass, 0);
    for (int i = 0; i < 20; i++)
      drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), PASS_V, 32'($urandom), ridx());
    check_val("b_fail_held", fail, 1);
    check_val("b_pass_held", pass, 0);
    check_val("b_retire", retire_count, 3);
    check_val("b_cycles", cycle_count, 4);
    drive(0, 1, 0, 0, 0, 0);

    // Hang: PC frozen at 0x40 from RUN cycle 10
    drive(1, 0, 0, 0, 32'h2000, 0);
    for (int k = 1; k <= 18; k++)
      drive(0, 0, 1'($urandom_range(0, 1)), nosig(), (k < 10) ? 32'h2000 + 32'(4 * k) : 32'h40, ridx());
    check_val("c_hang", hang, 1);
    check_val("c_cycles", cycle_count, 18);
    drive(0, 1, 0, 0, 0, 0);

    // Timeout with PC always moving
    pc = 32'h5000;
    drive(1, 0, 0, 0, pc, 0);
    for (int k = 1; k <= TO; k++) begin
      pc += 4;
      drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), nosig(), pc, ridx());
    end
    check_val("d_timeout", timeout, 1);
    check_val("d_cycles", cycle_count, 100);
    drive(0, 0, 0, 0, pc, 0);
    drive(0, 1, 0, 0, pc, 0);
    check_val("d_clr_timeout", timeout, 0);
    check_val("d_clr_done", done, 0);
    check_val("d_clr_cycles", cycle_count, 0);
    check_val("d_clr_retire", retire_count, 0);

    // Asynchronous reset mid-run, then restart
    pc = 32'h6000;
    drive(1, 0, 0, 0, pc, 0);
    for (int k = 1; k < 30; k++) begin
      pc += 4;
      drive(1, 0, 1, nosig(), pc, ridx());
    end
    pulse_reset(0);
    check_val("e_rst_cycles", cycle_count, 0);
    drive(1, 0, 0, 0, 32'h7000, 0);
    drive(0, 0, 1, nosig(), 32'h7004, 0);
    drive(0, 0, 1, nosig(), 32'h7008, 0);
    check_val("e_restart_cycles", cycle_count, 2);
    pulse_reset(1);
    drive(1, 0, 0, 0, 32'h8000, 0);
    check_val("e_entry_cycles", cycle_count, 0);
    drive(1, 0, 0, 0, 32'h8004, 0);
    check_val("e_first_run_cycle", cycle_count, 1);
    drive(0, 1, 0, 0, 0, 0);

    // Trace wrap: eleven retires with PCs 0x0..0x28
    drive(1, 0, 0, 0, 32'h100, 0);
    for (int i = 0; i <= 10; i++) drive(0, 0, 1, nosig(), 32'(4 * i), 0);
    trace_idx = 3'd0; #1;
`ifdef RISCV_TEST_MONITOR_TRACE_EN
    check_val("f_trace0", trace_pc, 32'h28);
    trace_idx = 3'd7; #1;
    check_val("f_trace7", trace_pc, 32'h0C);
    trace_idx = 3'd3; #1;
    check_val("f_trace3", trace_pc, 32'h1C);
`else
    check_val("f_trace0_off", trace_pc, 32'h0);
    trace_idx = 3'd7; #1;
    check_val("f_trace7_off", trace_pc, 32'h0);
`endif
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0);

    // Random segments with varying signature and PC-hold rates
    pc = 32'h100;
    for (int seg = 0; seg < 8; seg++) begin
      int sig_pct, hold_pct;
      sig_pct  = $urandom_range(0, 3);
      hold_pct = $urandom_range(0, 85);
      for (int c = 0; c < 300; c++) begin
        logic [31:0] d;
        int          sel;
        sel = $urandom_range(0, 99);
        if (sel < sig_pct)          d = PASS_V;
        else if (sel < 2 * sig_pct) d = FAIL_V;
        else                        d = $urandom;
        if ($urandom_range(0, 99) >= hold_pct) pc = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 499) == 0) pulse_reset(1'($urandom_range(0, 1)));
        drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) < 2),
              1'($urandom_range(0, 1)), d, pc, ridx());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
